// File: rtl/game_state_ctl.sv
// rtl/game_state_ctl.sv - session sequencer: start debounce, collision sync, game FSM, overlay
// Drives freeze/reset for the hero and enemy controllers plus the lives count and overlay colour.
module game_state_ctl #(
    parameter int LIVES           = 3,
    parameter int MAX_LEVEL       = 4,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int HOLD_CYCLES     = 65000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        player_collision,
    input  logic        level_done,
    input  logic [9:0]  level,
    input  logic [11:0] timer,
    output logic [2:0]  state,
    output logic        freeze,
    output logic        game_rst,
    output logic [2:0]  lives,
    output logic        overlay_en,
    output logic [11:0] overlay_rgb
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PLAY      = 3'd1;
    localparam logic [2:0] S_HIT       = 3'd2;
    localparam logic [2:0] S_LEVEL_UP  = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;
    localparam logic [2:0] S_WIN       = 3'd5;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic          btn_s1, btn_s2, btn_deb, btn_deb_q, press;
    logic [DW-1:0] deb_cnt;
    logic          col_s1, col_s2, col_s3;
    logic          hit;
    logic [HW-1:0] hold_cnt;
    logic          hold_done;

    logic [2:0]    state_nx;
    logic [2:0]    lives_nx;
    logic          game_rst_nx;
    logic          freeze_nx;
    logic          overlay_en_nx;
    logic [11:0]   overlay_rgb_nx;

    // The debounce counter only runs while the synchronised input disagrees with the
    // debounced level; press is registered so it lands DEBOUNCE_CYCLES+3 after the pin edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
            press     <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            btn_s1    <= btn_start;
            btn_s2    <= btn_s1;
            btn_deb_q <= btn_deb;
            press     <= btn_deb & ~btn_deb_q;
            if (btn_s2 == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_deb <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1 <= 1'b0;
            col_s2 <= 1'b0;
            col_s3 <= 1'b0;
        end else begin
            col_s1 <= player_collision;
            col_s2 <= col_s1;
            col_s3 <= col_s2;
        end
    end

    assign hit       = col_s2 & ~col_s3;
    assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));

    // State register; outputs are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            lives       <= 3'(LIVES);
            game_rst    <= 1'b0;
            freeze      <= 1'b1;
            overlay_en  <= 1'b1;
            overlay_rgb <= 12'h00f;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nx;
            lives       <= lives_nx;
            game_rst    <= game_rst_nx;
            freeze      <= freeze_nx;
            overlay_en  <= overlay_en_nx;
            overlay_rgb <= overlay_rgb_nx;
            if (state_nx != state)
                hold_cnt <= '0;
            else if (state == S_HIT || state == S_LEVEL_UP)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
        end
    end

    always_comb begin
        state_nx    = state;
        lives_nx    = lives;
        game_rst_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (press) begin
                    state_nx    = S_PLAY;
                    lives_nx    = 3'(LIVES);
                    game_rst_nx = 1'b1;
                end
            end
            S_PLAY: begin
                if (level_done) begin
                    state_nx = (level == 10'(MAX_LEVEL - 1)) ? S_WIN : S_LEVEL_UP;
                end else if (timer == 12'd0) begin
                    state_nx = S_GAME_OVER;
                    lives_nx = 3'd0;
                end else if (hit) begin
                    if (lives > 3'd1) begin
                        state_nx = S_HIT;
                        lives_nx = lives - 3'd1;
                    end else begin
                        state_nx = S_GAME_OVER;
                        lives_nx = 3'd0;
                    end
                end
            end
            S_HIT: begin
                if (hold_done) begin
                    state_nx    = S_PLAY;
                    game_rst_nx = 1'b1;
                end
            end
            S_LEVEL_UP: begin
                // Level management already repositions the hero, so no game_rst here.
                if (hold_done)
                    state_nx = S_PLAY;
            end
            S_GAME_OVER, S_WIN: begin
                if (press) begin
                    state_nx = S_IDLE;
                    lives_nx = 3'(LIVES);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        freeze_nx      = (state_nx != S_PLAY);
        overlay_en_nx  = 1'b0;
        overlay_rgb_nx = 12'h000;
        case (state_nx)
            S_IDLE: begin
                overlay_en_nx  = 1'b1;
                overlay_rgb_nx = 12'h00f;
            end
            S_HIT: begin
                overlay_en_nx  = 1'b1;
                overlay_rgb_nx = 12'hff0;
            end
            S_GAME_OVER: begin
                overlay_en_nx  = 1'b1;
                overlay_rgb_nx = 12'hf00;
            end
            S_WIN: begin
                overlay_en_nx  = 1'b1;
                overlay_rgb_nx = 12'h0f0;
            end
            default: begin
                overlay_en_nx  = 1'b0;
                overlay_rgb_nx = 12'h000;
            end
        endcase
    end

endmodule
